// File: rtl/random_range_generator.sv
// Uniform random draws from a signed [min, max] window using a Fibonacci LFSR
// with rejection sampling, so every value in the window is equally likely.
module random_range_generator #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
    parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    input  logic                    in_seed_load,
    input  logic        [WIDTH-1:0] in_seed,
    input  logic                    in_start,
    input  logic signed [WIDTH-1:0] in_min,
    input  logic signed [WIDTH-1:0] in_max,
    input  logic                    in_ready,
    output logic                    out_busy,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_random,
    output logic                    out_error,
    output logic              [7:0] out_attempts
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t                  r_state;
    logic        [WIDTH-1:0] r_lfsr;
    logic        [WIDTH-1:0] r_range;
    logic        [WIDTH-1:0] r_mask;
    logic signed [WIDTH-1:0] r_min;
    logic signed [WIDTH-1:0] r_random;
    logic                    r_error;
    logic              [7:0] r_attempts;

    logic        [WIDTH-1:0] w_range;
    logic        [WIDTH-1:0] w_step;
    logic        [WIDTH-1:0] w_cand;
    logic                    w_bad_order;

    function automatic logic [WIDTH-1:0] fix_zero(input logic [WIDTH-1:0] v);
        return (v == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : v;
    endfunction

    // Smallest all-ones mask covering the range, so candidates are never biased.
    function automatic logic [WIDTH-1:0] smear(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        m = v;
        for (int i = 0; i < WIDTH; i++) begin
            m = m | (m >> 1);
        end
        return m;
    endfunction

    // The low WIDTH bits of the (WIDTH+1)-bit difference are the same as a WIDTH-bit subtract.
    assign w_range     = in_max - in_min;
    assign w_bad_order = (in_min > in_max);
    assign w_step      = fix_zero({r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)});
    assign w_cand      = w_step & r_mask;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_state    <= S_IDLE;
            r_lfsr     <= fix_zero(RESET_SEED);
            r_range    <= '0;
            r_mask     <= '0;
            r_min      <= '0;
            r_random   <= '0;
            r_error    <= 1'b0;
            r_attempts <= '0;
        end else if (in_seed_load) begin
            r_lfsr  <= fix_zero(in_seed);
            r_state <= S_IDLE;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        r_min      <= in_min;
                        r_range    <= w_range;
                        r_mask     <= smear(w_range);
                        r_attempts <= '0;
                        r_error    <= w_bad_order;
                        r_state    <= w_bad_order ? S_DONE : S_DRAW;
                    end
                end
                S_DRAW: begin
                    r_lfsr <= w_step;
                    if (r_attempts != 8'hFF) begin
                        r_attempts <= r_attempts + 8'd1;
                    end
                    if (w_cand <= r_range) begin
                        r_random <= r_min + $signed(w_cand);
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (in_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_busy     = (r_state == S_DRAW);
    assign out_valid    = (r_state == S_DONE);
    assign out_random   = r_random;
    assign out_error    = r_error;
    assign out_attempts = r_attempts;

endmodule

// File: tb/tb_random_range_generator.sv
// Scoreboard bench for random_range_generator: directed draws with hand-derived
// results plus a long run checking range membership and value spread.
module tb_random_range_generator;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                seed_load;
    logic        [W-1:0] seed;
    logic                start;
    logic signed [W-1:0] vmin;
    logic signed [W-1:0] vmax;
    logic                ready;
    logic                busy;
    logic                valid;
    logic signed [W-1:0] rnd;
    logic                err;
    logic          [7:0] att;

    random_range_generator #(.WIDTH(W), .TAPS(16'hB400), .RESET_SEED(16'h0001)) dut (
        .in_clock    (clk),
        .in_reset    (rst),
        .in_seed_load(seed_load),
        .in_seed     (seed),
        .in_start    (start),
        .in_min      (vmin),
        .in_max      (vmax),
        .in_ready    (ready),
        .out_busy    (busy),
        .out_valid   (valid),
        .out_random  (rnd),
        .out_error   (err),
        .out_attempts(att)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                  exact;
        logic signed [W-1:0] val;
        logic signed [W-1:0] lo;
        logic signed [W-1:0] hi;
        logic                err;
        logic          [7:0] att;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hist[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exact(input int v, input bit e, input int a);
        exp_t t;
        t.exact = 1'b1; t.val = 16'(v); t.lo = '0; t.hi = '0; t.err = e; t.att = 8'(a);
        q.push_back(t);
    endtask

    task automatic push_range(input int lo, input int hi);
        exp_t t;
        t.exact = 1'b0; t.val = '0; t.lo = 16'(lo); t.hi = 16'(hi); t.err = 1'b0; t.att = '0;
        q.push_back(t);
    endtask

    // Monitor: pops one expectation per accepted output.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got random=%0d with no draw outstanding", rnd);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.exact) begin
                    chk("random", rnd, e.val);
                    chk("error", err, e.err);
                    chk("attempts", att, e.att);
                end else begin
                    chk("in_range", (rnd >= e.lo && rnd <= e.hi), 1);
                    chk("error_clear", err, 0);
                    chk("attempts_nonzero", (att != 8'd0), 1);
                    if (rnd >= e.lo && rnd <= e.hi) hist[int'(rnd) - int'(e.lo)]++;
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic do_start(input int lo, input int hi);
        start = 1'b1; vmin = 16'(lo); vmax = 16'(hi);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_seen", valid, 1);
    endtask

    task automatic accept();
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic load_seed(input logic [W-1:0] s);
        seed_load = 1'b1; seed = s;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0;
        vmin = '0; vmax = '0; ready = 1'b0;
        for (int k = 0; k < 7; k++) hist[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_random", rnd, 0);
        chk("rst_error", err, 0);
        chk("rst_attempts", att, 0);
        chk("rst_lfsr", dut.r_lfsr, 16'h0001);
        rst = 1'b0;
        @(posedge clk); #1;

        // min=max=5 from seed 1: one step to 0x0002, accepted at once.
        push_exact(5, 0, 1);
        do_start(5, 5);
        chk("lat_busy", busy, 1);
        chk("lat_valid_early", valid, 0);
        @(posedge clk); #1;
        chk("lat_valid", valid, 1);
        chk("lfsr_after_one", dut.r_lfsr, 16'h0002);
        accept();
        chk("idle_after_accept", valid, 0);

        // Seed 1, [0,3]: candidate 2 -> result 2; held while ready low.
        load_seed(16'h0001);
        chk("seed_loaded", dut.r_lfsr, 16'h0001);
        push_exact(2, 0, 1);
        do_start(0, 3);
        wait_valid(5);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", valid, 1);
            chk("hold_random", rnd, 2);
            chk("hold_attempts", att, 1);
            chk("hold_lfsr", dut.r_lfsr, 16'h0002);
        end
        accept();

        // min > max: error result next cycle, LFSR untouched, random keeps 2.
        push_exact(2, 1, 0);
        do_start(3, -2);
        chk("err_valid", valid, 1);
        chk("err_flag", err, 1);
        chk("err_busy", busy, 0);
        chk("err_lfsr", dut.r_lfsr, 16'h0002);
        accept();
        chk("err_idle_valid", valid, 0);
        chk("err_idle_busy", busy, 0);

        // Seed 7: 0x0E (cand 6 rejected), 0x1C (cand 4) -> 4 after 2 attempts.
        load_seed(16'h0007);
        push_exact(4, 0, 2);
        do_start(0, 5);
        wait_valid(10);
        accept();
        chk("lfsr_after_reject", dut.r_lfsr, 16'h001C);
        // 0x38, mask 3 -> cand 0 -> -8.
        push_exact(-8, 0, 1);
        do_start(-8, -6);
        wait_valid(10);
        accept();
        // range 103, mask 0x7F: 0x70 (112) rejected, 0xE0 -> 96 -> 93.
        push_exact(93, 0, 2);
        do_start(-3, 100);
        wait_valid(10);
        accept();
        // Full range: 0x1C0 accepted -> -32768 + 448 = -32320.
        push_exact(-32320, 0, 1);
        do_start(-32768, 32767);
        wait_valid(10);
        accept();
        chk("lfsr_full_range", dut.r_lfsr, 16'h01C0);

        load_seed(16'h0000);
        chk("zero_seed_fixed", dut.r_lfsr, 16'h0001);

        // Abort a draw with an asynchronous reset while busy; start held high meanwhile.
        load_seed(16'h0055);
        do_start(0, 5);
        chk("abort_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        start = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_lfsr", dut.r_lfsr, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        chk("start_ignored_in_reset", busy, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_pulse", valid, 0);
        end

        // Long run over [-4,2] with ready held high.
        load_seed(16'hACE1);
        ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            int n;
            push_range(-4, 2);
            do_start(-4, 2);
            n = 0;
            while ((busy || valid) && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL draw_timeout: draw %0d still busy=%0b valid=%0b", i, busy, valid);
            end
        end
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("spread_value_%0d_count_%0d", k - 4, hist[k]),
                (hist[k] >= 1287 && hist[k] <= 1571), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
